// File: rtl/ram_arb.sv
// ram_arb: arbitrates ports A and B onto a single-port byte-wide RAM and returns read data to the requesting port
module ram_arb (
   input  logic        clk,
   input  logic        reset,
   input  logic        RR,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [14:0] a_addr,
   input  logic [7:0]  a_din,
   output logic        a_ack,
   output logic [7:0]  a_rdata,
   output logic        a_rvalid,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [14:0] b_addr,
   input  logic [7:0]  b_din,
   output logic        b_ack,
   output logic [7:0]  b_rdata,
   output logic        b_rvalid,
   output logic        ram_sel,
   output logic        ram_we,
   output logic [14:0] ram_addr,
   output logic [7:0]  ram_din,
   input  logic [7:0]  ram_dout
);
   logic ea, eb, ga, gb, last_b, s1_v, s1_b;
   assign ea = a_req & ~a_ack;
   assign eb = b_req & ~b_ack;
   assign ga = ea & (~eb | ~RR | last_b);
   assign gb = eb & ~ga;
   // Register the winning command onto the RAM pins and remember who won
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ram_sel  <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         a_ack    <= 1'b0;
         b_ack    <= 1'b0;
         last_b   <= 1'b1;
      end else begin
         ram_sel <= ga | gb;
         ram_we  <= ga ? a_we : gb & b_we;
         a_ack   <= ga;
         b_ack   <= gb;
         if (ga | gb) begin
            ram_addr <= ga ? a_addr : b_addr;
            ram_din  <= ga ? a_din : b_din;
            last_b   <= gb;
         end
      end
   // Tag each read alongside the RAM's read register, then hand ram_dout to the tagged port
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1_v     <= 1'b0;
         s1_b     <= 1'b0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         s1_v     <= ram_sel & ~ram_we;
         s1_b     <= b_ack;
         a_rvalid <= s1_v & ~s1_b;
         b_rvalid <= s1_v & s1_b;
         if (s1_v & ~s1_b) a_rdata <= ram_dout;
         if (s1_v & s1_b) b_rdata <= ram_dout;
      end
endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: randomized and directed checks of ram_arb against a transaction-level model
module tb_ram_arb;
   logic clk = 0, reset = 1, RR = 1;
   logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
   logic [14:0] a_addr = 0, b_addr = 0;
   logic [7:0] a_din = 0, b_din = 0, ram_dout = 0;
   logic a_ack, a_rvalid, b_ack, b_rvalid, ram_sel, ram_we;
   logic [7:0] a_rdata, b_rdata, ram_din;
   logic [14:0] ram_addr;
   int total = 0, bad = 0, cyc = 0;
   bit on = 0;

   ram_arb dut (.clk(clk), .reset(reset), .RR(RR),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

   always #5 clk = ~clk;

   logic [7:0] mem [32768];
   logic [7:0] shadow [32768];
   initial for (int i = 0; i < 32768; i++) begin
      mem[i] = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
   end
   always @(posedge clk)
      if (ram_sel) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else ram_dout <= mem[ram_addr];
      end

   typedef struct {int due; bit b; logic [7:0] d;} rd_t;
   rd_t q[$];
   bit m_aack, m_back, m_sel, m_we, m_last = 1, m_arv, m_brv, ea, eb, ga, gb;
   logic [14:0] m_addr;
   logic [7:0] m_din, m_ard, m_brd;

   always @(posedge clk) begin
      if (reset) begin
         {m_aack, m_back, m_sel, m_we, m_arv, m_brv} = '0;
         m_addr = 0; m_din = 0; m_ard = 0; m_brd = 0; m_last = 1;
         q.delete();
      end else begin
         cyc++;
         ea = a_req && !m_aack;
         eb = b_req && !m_back;
         if (ea && eb) ga = RR ? m_last : 1'b1;
         else ga = ea;
         gb = eb && !ga;
         m_arv = 0; m_brv = 0;
         if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].b) begin m_brv = 1; m_brd = q[0].d; end
            else begin m_arv = 1; m_ard = q[0].d; end
            void'(q.pop_front());
         end
         m_sel = ga || gb;
         m_we = 0;
         if (m_sel) begin
            m_we = ga ? a_we : b_we;
            m_addr = ga ? a_addr : b_addr;
            m_din = ga ? a_din : b_din;
            m_last = gb;
            if (m_we) shadow[m_addr] = m_din;
            else q.push_back('{cyc + 2, gb, shadow[m_addr]});
         end
         m_aack = ga; m_back = gb;
      end
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", n, $time, act, exp);
      end
   endtask

   always @(negedge clk)
      if (on && !reset) begin
         chk("a_ack", 32'(a_ack), 32'(m_aack));
         chk("b_ack", 32'(b_ack), 32'(m_back));
         chk("ram_sel", 32'(ram_sel), 32'(m_sel));
         chk("ram_we", 32'(ram_we), 32'(m_we));
         chk("ram_addr", 32'(ram_addr), 32'(m_addr));
         chk("ram_din", 32'(ram_din), 32'(m_din));
         chk("a_rvalid", 32'(a_rvalid), 32'(m_arv));
         chk("b_rvalid", 32'(b_rvalid), 32'(m_brv));
         chk("a_rdata", 32'(a_rdata), 32'(m_ard));
         chk("b_rdata", 32'(b_rdata), 32'(m_brd));
      end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit p, input bit we, input logic [14:0] ad, input logic [7:0] d);
      bit got = 0;
      if (p) begin b_req = 1; b_we = we; b_addr = ad; b_din = d; end
      else begin a_req = 1; a_we = we; a_addr = ad; a_din = d; end
      for (int i = 0; i < 8 && !got; i++) begin
         step;
         got = p ? b_ack : a_ack;
      end
      if (!got) chk("ack_timeout", 0, 1);
      if (p) b_req = 0;
      else a_req = 0;
   endtask

   task automatic wait_rv(input bit p, output logic [7:0] d);
      bit got = 0;
      d = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         step;
         got = p ? b_rvalid : a_rvalid;
      end
      if (!got) chk("rvalid_timeout", 0, 1);
      else d = p ? b_rdata : a_rdata;
   endtask

   logic [7:0] d;
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 0;
      on = 1;
      step;
      a_req = 1; a_we = 1; a_addr = 15'h1234; a_din = 8'h5A;
      step;
      chk("wr_ack", 32'(a_ack), 1);
      chk("wr_pins", {15'(0), ram_sel, ram_we, ram_addr, ram_din}, {15'(0), 2'b11, 15'h1234, 8'h5A});
      a_we = 0;
      step;
      chk("gap_ack", 32'(a_ack), 0);
      chk("gap_sel", 32'(ram_sel), 0);
      step;
      chk("rd_ack", 32'(a_ack), 1);
      chk("rd_pins", {16'(0), ram_sel, ram_we, ram_addr}, {16'(0), 2'b10, 15'h1234});
      a_req = 0;
      step;
      chk("rd_idle", 32'(ram_sel), 0);
      step;
      chk("rd_rvalid", 32'(a_rvalid), 1);
      chk("rd_data", 32'(a_rdata), 32'h5A);
      chk("rd_b_rvalid", 32'(b_rvalid), 0);
      step;
      chk("rvalid_pulse", 32'(a_rvalid), 0);
      req(0, 1, 15'h0100, 8'h11);
      req(1, 1, 15'h0101, 8'h22);
      req(0, 0, 15'h0100, 0);
      wait_rv(0, d);
      chk("even_byte", 32'(d), 32'h11);
      req(1, 0, 15'h0101, 0);
      wait_rv(1, d);
      chk("odd_byte", 32'(d), 32'h22);
      chk("a_rdata_hold", 32'(a_rdata), 32'h11);
      b_req = 1; b_we = 0; b_addr = 15'h0042;
      for (int i = 0; i < 6; i++) begin
         step;
         chk("b_hold_ack", 32'(b_ack), 32'(i % 2 == 0));
         chk("b_hold_sel", 32'(ram_sel), 32'(i % 2 == 0));
      end
      b_req = 0;
      repeat (4) step;
      req(0, 0, 15'h1234, 0);
      @(negedge clk) reset = 1;
      #1 chk("reset_outs", {a_ack, b_ack, a_rvalid, b_rvalid, ram_sel, ram_we, ram_addr, ram_din, a_rdata, b_rdata}, 0);
      @(posedge clk);
      @(negedge clk) reset = 0;
      for (int i = 0; i < 4; i++) begin
         step;
         chk("no_rvalid_after_reset", 32'(a_rvalid), 0);
      end
      @(negedge clk) reset = 1;
      a_req = 1; a_we = 0; a_addr = 15'h0100;
      b_req = 1; b_we = 0; b_addr = 15'h0101;
      RR = 1;
      @(posedge clk);
      @(negedge clk) reset = 0;
      for (int i = 0; i < 6; i++) begin
         step;
         chk("rr_a_ack", 32'(a_ack), 32'(i % 2 == 0));
         chk("rr_b_ack", 32'(b_ack), 32'(i % 2 == 1));
      end
      RR = 0;
      for (int i = 0; i < 6; i++) begin
         step;
         chk("fp_one_ack", 32'(a_ack ^ b_ack), 1);
      end
      a_req = 0; b_req = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) RR = 1'($urandom);
         if (!a_req || a_ack) begin
            a_req = 1'($urandom_range(0, 2) != 0);
            a_we = 1'($urandom);
            a_addr = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
            a_din = 8'($urandom);
         end
         if (!b_req || b_ack) begin
            b_req = 1'($urandom_range(0, 2) != 0);
            b_we = 1'($urandom);
            b_addr = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
            b_din = 8'($urandom);
         end
         step;
      end
      a_req = 0; b_req = 0;
      repeat (5) step;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
